// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem data memory.
// Access-size encoding, default widths, byte-enable and alignment helpers.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 14;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Lane enables for an access; misaligned sub-word addresses align down.
  function automatic logic [3:0] byte_en(input size_e sz, input logic [1:0] lo);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
    logic bad;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word array with per-lane write enables and a read-first registered read port.
// The read register clears asynchronously so the load path resets to zero.
module dmem_ram #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  localparam int DEPTH = 2 ** AW;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  // Lane-masked store; no reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) begin
        mem_q[idx_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Read samples the pre-write contents when it collides with a store.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= 32'd0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem.sv
// Byte-addressable load/store data memory: store steering and load extension.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RDEN,
  input  logic              WEN,
  input  logic [1:0]        BYTE_SEL,
  input  logic              SIGN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  output logic [DATA_W-1:0] DATA_OUT
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic              MISALIGN
`endif
);

  size_e       sz_s;
  logic [3:0]  be_s;
  logic [3:0]  we_s;
  logic        re_s;
  logic        ok_s;
  logic [31:0] wdata_s;
  logic [31:0] rdata_s;
  logic [31:0] dout_s;
  logic [7:0]  lane_s;
  logic [15:0] pair_s;

  size_e       sz_q;
  logic [1:0]  lo_q;
  logic        sign_q;

  assign sz_s = size_e'(BYTE_SEL);

`ifdef DMEM_MISALIGN_CHK_EN
  assign ok_s = !is_misaligned(sz_s, ADDR[1:0]);
`else
  assign ok_s = 1'b1;
`endif

  // Replicate store data across lanes; the byte enables pick the target.
  always_comb begin
    be_s = byte_en(sz_s, ADDR[1:0]);
    case (sz_s)
      SZ_BYTE: wdata_s = {4{DATA_IN[7:0]}};
      SZ_HALF: wdata_s = {2{DATA_IN[15:0]}};
      default: wdata_s = DATA_IN;
    endcase
  end

  // RST_N gates stores because the array itself has no reset.
  assign we_s = (WEN && RST_N && ok_s) ? be_s : 4'b0000;
  assign re_s = RDEN && ok_s;

  dmem_ram #(
    .AW(ADDR_W - 2)
  ) u_ram (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .re_i    (re_s),
    .we_i    (we_s),
    .idx_i   (ADDR[ADDR_W-1:2]),
    .wdata_i (wdata_s),
    .rdata_o (rdata_s)
  );

  // Load format travels alongside the registered raw word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sz_q   <= SZ_BYTE;
      lo_q   <= 2'b00;
      sign_q <= 1'b0;
    end else if (re_s) begin
      sz_q   <= sz_s;
      lo_q   <= ADDR[1:0];
      sign_q <= SIGN;
    end
  end

  // Extract and extend from registered state only, so the output is glitch-stable.
  always_comb begin
    lane_s = rdata_s[8*lo_q +: 8];
    pair_s = lo_q[1] ? rdata_s[31:16] : rdata_s[15:0];
    case (sz_q)
      SZ_BYTE: dout_s = {{24{sign_q & lane_s[7]}}, lane_s};
      SZ_HALF: dout_s = {{16{sign_q & pair_s[15]}}, pair_s};
      default: dout_s = rdata_s;
    endcase
  end

  assign DATA_OUT = dout_s;

`ifdef DMEM_MISALIGN_CHK_EN
  logic mis_q;

  // One-cycle flag for each misaligned access attempt.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= (RDEN || WEN) && !ok_s;
    end
  end

  assign MISALIGN = mis_q;
`endif

endmodule

// File: tb/tb_dmem.sv
// Self-checking bench for dmem: directed scenarios plus random traffic
// checked against a byte-array reference model.
module tb_dmem;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        RDEN = 1'b0;
  logic        WEN = 1'b0;
  logic [1:0]  BYTE_SEL = 2'b00;
  logic        SIGN = 1'b0;
  logic [13:0] ADDR = 14'd0;
  logic [31:0] DATA_IN = 32'd0;
  logic [31:0] DATA_OUT;
`ifdef DMEM_MISALIGN_CHK_EN
  logic        MISALIGN;
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem_m [16384];
  logic [31:0] exp_out = 32'd0;
  logic        exp_mis = 1'b0;

  dmem dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .RDEN     (RDEN),
    .WEN      (WEN),
    .BYTE_SEL (BYTE_SEL),
    .SIGN     (SIGN),
    .ADDR     (ADDR),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT)
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    .MISALIGN (MISALIGN)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic int m_bytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_bad(input logic [1:0] sz, input int a);
    int n;
    n = m_bytes(sz);
    return CHK_EN && ((a % n) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input bit sg, input int a);
    int n;
    int base;
    logic [31:0] v;
    n = m_bytes(sz);
    base = a - (a % n);
    v = 32'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[base + i];
    if (sg && n < 4 && v[8*n-1]) begin
      for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic m_store(input logic [1:0] sz, input int a, input logic [31:0] d);
    int n;
    int base;
    n = m_bytes(sz);
    base = a - (a % n);
    if (!m_bad(sz, a)) begin
      for (int i = 0; i < n; i++) mem_m[base + i] = d[8*i +: 8];
    end
  endtask

  // One access cycle; the model is read before it is written (read-first).
  task automatic access(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                        input int a, input logic [31:0] d);
    @(negedge CLK);
    RDEN = rd; WEN = wr; BYTE_SEL = sz; SIGN = sg; ADDR = a[13:0]; DATA_IN = d;
    @(posedge CLK);
    #1;
    exp_mis = (rd || wr) && m_bad(sz, a);
    if (rd && !m_bad(sz, a)) exp_out = m_load(sz, sg, a);
    if (wr) m_store(sz, a, d);
    RDEN = 1'b0; WEN = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    tests++;
    if (DATA_OUT !== 32'd0) begin
      fails++; $display("FAIL reset_out: got %h expected %h", DATA_OUT, 32'd0);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int w = 0; w < 64; w++) access(1'b0, 1'b1, 2'b10, 1'b0, 4 * w, 32'd0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 0, 32'hDEADBEEF);
    access(1'b1, 1'b0, 2'b10, 1'b0, 0, 32'd0);
    tests++;
    if (DATA_OUT !== 32'hDEADBEEF) begin
      fails++; $display("FAIL reset_wr_rd: got %h expected %h", DATA_OUT, 32'hDEADBEEF);
    end
  endtask

  task automatic test_subword_store;
    logic [31:0] exp_c [3];
    int          addr_c [3];
    logic [1:0]  sz_c [3];
    exp_c  = '{32'h000000EF, 32'h0000BEEF, 32'h000000EF};
    addr_c = '{4, 8, 12};
    sz_c   = '{2'b00, 2'b01, 2'b00};
    for (int i = 0; i < 3; i++) begin
      access(1'b0, 1'b1, sz_c[i], (i == 2), addr_c[i], 32'hDEADBEEF);
      access(1'b1, 1'b0, 2'b10, 1'b0, addr_c[i], 32'd0);
      tests++;
      if (DATA_OUT !== exp_c[i]) begin
        fails++; $display("FAIL subword_store[%0d]: got %h expected %h", i, DATA_OUT, exp_c[i]);
      end
    end
  endtask

  task automatic test_loads;
    logic [31:0] exp_c [4];
    int          addr_c [4];
    logic [1:0]  sz_c [4];
    bit          sg_c [4];
    exp_c  = '{32'hFFFFFFEF, 32'h000000EF, 32'hFFFFBEEF, 32'hFFFFFFBE};
    addr_c = '{8, 8, 8, 9};
    sz_c   = '{2'b00, 2'b00, 2'b01, 2'b00};
    sg_c   = '{1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, sz_c[i], sg_c[i], addr_c[i], 32'd0);
      tests++;
      if (DATA_OUT !== exp_c[i]) begin
        fails++; $display("FAIL load[%0d]: got %h expected %h", i, DATA_OUT, exp_c[i]);
      end
    end
  endtask

  task automatic test_misalign;
    access(1'b0, 1'b1, 2'b10, 1'b0, 0, 32'd0);
    access(1'b1, 1'b0, 2'b10, 1'b0, 0, 32'd0);
    access(1'b0, 1'b1, 2'b10, 1'b0, 1, 32'hDEADBEEF);
`ifdef DMEM_MISALIGN_CHK_EN
    tests++;
    if (MISALIGN !== 1'b1) begin
      fails++; $display("FAIL misalign_wr_flag: got %b expected 1", MISALIGN);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 1, 32'd0);
    tests++;
    if (DATA_OUT !== 32'd0 || MISALIGN !== 1'b1) begin
      fails++; $display("FAIL misalign_rd_hold: got %h/%b expected %h/1", DATA_OUT, MISALIGN, 32'd0);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 0, 32'd0);
    tests++;
    if (DATA_OUT !== 32'd0 || MISALIGN !== 1'b0) begin
      fails++; $display("FAIL misalign_mem_kept: got %h/%b expected %h/0", DATA_OUT, MISALIGN, 32'd0);
    end
`else
    access(1'b1, 1'b0, 2'b10, 1'b0, 1, 32'd0);
    tests++;
    if (DATA_OUT !== 32'hDEADBEEF) begin
      fails++; $display("FAIL misalign_word: got %h expected %h", DATA_OUT, 32'hDEADBEEF);
    end
    access(1'b1, 1'b0, 2'b01, 1'b0, 3, 32'd0);
    tests++;
    if (DATA_OUT !== 32'h0000DEAD) begin
      fails++; $display("FAIL misalign_half: got %h expected %h", DATA_OUT, 32'h0000DEAD);
    end
`endif
  endtask

  task automatic test_collision;
    access(1'b0, 1'b1, 2'b10, 1'b0, 0, 32'h11111111);
    access(1'b1, 1'b1, 2'b10, 1'b0, 0, 32'h22222222);
    tests++;
    if (DATA_OUT !== 32'h11111111) begin
      fails++; $display("FAIL collision_old: got %h expected %h", DATA_OUT, 32'h11111111);
    end
    access(1'b1, 1'b0, 2'b10, 1'b0, 0, 32'd0);
    tests++;
    if (DATA_OUT !== 32'h22222222) begin
      fails++; $display("FAIL collision_new: got %h expected %h", DATA_OUT, 32'h22222222);
    end
  endtask

  task automatic test_hold_reset;
    access(1'b1, 1'b0, 2'b10, 1'b0, 0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      tests++;
      if (DATA_OUT !== 32'h22222222) begin
        fails++; $display("FAIL hold[%0d]: got %h expected %h", i, DATA_OUT, 32'h22222222);
      end
    end
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    tests++;
    if (DATA_OUT !== 32'd0) begin
      fails++; $display("FAIL async_reset: got %h expected %h", DATA_OUT, 32'd0);
    end
    @(negedge CLK);
    RDEN = 1'b1; WEN = 1'b1; BYTE_SEL = 2'b10; ADDR = 14'd0; DATA_IN = 32'h33333333;
    @(posedge CLK);
    #1;
    tests++;
    if (DATA_OUT !== 32'd0) begin
      fails++; $display("FAIL reset_blocks_rd: got %h expected %h", DATA_OUT, 32'd0);
    end
    @(negedge CLK);
    RST_N = 1'b1; WEN = 1'b0;
    @(posedge CLK);
    #1;
    RDEN = 1'b0;
    exp_out = m_load(2'b10, 1'b0, 0);
    tests++;
    if (DATA_OUT !== exp_out || exp_out !== 32'h22222222) begin
      fails++; $display("FAIL reset_retain: got %h expected %h", DATA_OUT, 32'h22222222);
    end
  endtask

  task automatic test_random;
    bit          rd;
    bit          wr;
    logic [1:0]  sz;
    bit          sg;
    int          a;
    logic [31:0] d;
    for (int i = 0; i < 300; i++) begin
      rd = ($urandom_range(3, 0) != 0);
      wr = ($urandom_range(1, 0) != 0);
      sz = 2'($urandom_range(3, 0));
      sg = ($urandom_range(1, 0) != 0);
      a  = $urandom_range(255, 0);
      d  = $urandom;
      access(rd, wr, sz, sg, a, d);
      tests++;
      if (DATA_OUT !== exp_out) begin
        fails++;
        $display("FAIL random[%0d] rd=%0d wr=%0d sz=%0d sg=%0d a=%0d: got %h expected %h",
                 i, rd, wr, sz, sg, a, DATA_OUT, exp_out);
      end
`ifdef DMEM_MISALIGN_CHK_EN
      tests++;
      if (MISALIGN !== exp_mis) begin
        fails++; $display("FAIL random_mis[%0d]: got %b expected %b", i, MISALIGN, exp_mis);
      end
`endif
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem_m[i] = 8'h00;
    test_reset;
    test_subword_store;
    test_loads;
    test_misalign;
    test_collision;
    test_hold_reset;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem.md
Name: dmem

Overview:
- Byte-addressable 16 KiB data memory for the core's load/store stage.
- Holds a 32-bit-wide word array with byte-lane write enables.
- Supports byte, halfword and word stores.
- Supports byte, halfword and word loads with selectable sign or zero extension; the load result is registered.

Parameters:
- ADDR_W, 14, byte-address width; depth = 2^(ADDR_W-2) words (4096).
- DATA_W, 32, data width; fixed at 32, not to be overridden.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- RDEN  input  1  read enable.
- WEN  input  1  write enable.
- BYTE_SEL  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- SIGN  input  1  load extension: 1 sign-extend, 0 zero-extend; ignored for word and for writes.
- ADDR  input  ADDR_W  byte address.
- DATA_IN  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- DATA_OUT  output  32  registered load result.

Behaviour:
- Addressing:
  - Word index = ADDR[ADDR_W-1:2].
  - Byte lane = ADDR[1:0] for bytes; halfword lane pair = ADDR[1] (lanes 0-1 or 2-3). ADDR[0] is ignored for halfwords.
  - ADDR[1:0] is ignored for words.
  - Misaligned accesses therefore align down silently; no exception is raised.
- Little-endian: lane k holds bits [8k+7:8k].
- Write (WEN=1) on rising CLK:
  - Byte: DATA_IN[7:0] goes to the addressed lane.
  - Half: DATA_IN[15:0] goes to the addressed lane pair.
  - Word: all 32 bits are written.
  - Unselected lanes keep their contents.
- Read (RDEN=1) on rising CLK:
  - DATA_OUT updates with the extracted, extended value; latency is one cycle.
  - Byte: lane value, bits [31:8] = SIGN ? lane[7] : 0.
  - Half: pair value, bits [31:16] = SIGN ? pair[15] : 0.
  - Word: full word.
- RDEN=0: DATA_OUT holds its last value.
- RDEN=1 and WEN=1 on the same word in the same cycle: read-first; DATA_OUT gets the pre-write contents and the write still commits.
- Reset:
  - RST_N low asynchronously clears DATA_OUT to 0 and blocks reads and writes while asserted.
  - Memory array contents are not cleared by reset.
  - Array is zero-initialised at time 0 (simulation init / FPGA bitstream init).
- Reset released mid-operation: the first active edge after deassertion performs the requested access normally.
- BYTE_SEL=11 behaves exactly as 10.
- X/unknown inputs are not required to be handled.

Optional Feature:
- Macro DMEM_MISALIGN_CHK_EN.
- When defined:
  - Adds output MISALIGN (1 bit, registered, reset 0).
  - On any access with RDEN or WEN high, MISALIGN is set for one cycle when ADDR[0]!=0 for a halfword, or ADDR[1:0]!=0 for a word.
  - A misaligned write is suppressed (memory unchanged).
  - A misaligned read leaves DATA_OUT unchanged.
- When undefined: no MISALIGN port; misaligned accesses align down as above.

Decomposition:
- Package dmem_pkg:
  - enum size_e {SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11}.
  - Localparams DMEM_ADDR_W=14 and DMEM_DATA_W=32.
  - Function computing the 4-bit byte-enable from size and ADDR[1:0].
- One sub-module dmem_ram:
  - Word array with 4 byte-lane write enables and read-first synchronous read.
  - Top level does store steering (byte-enable and lane replication of DATA_IN).
  - Top level does load extraction/extension on the raw word.

Test Plan:
- Reset: RST_N=0 -> DATA_OUT=0. Write word 32'hDEADBEEF at ADDR 0, then read word at ADDR 0 -> DATA_OUT=32'hDEADBEEF one cycle after the read edge.
- Sub-word stores into zeroed memory, each data 32'hDEADBEEF:
  - Byte at ADDR 4, read word at 4 -> 32'h000000EF.
  - Half at ADDR 8, read word at 8 -> 32'h0000BEEF.
  - Byte with SIGN=1 at ADDR 12, read word at 12 -> 32'h000000EF (SIGN ignored on write).
- Loads from word 8 (holding 32'h0000BEEF):
  - Byte, SIGN=1, ADDR 8 -> 32'hFFFFFFEF; SIGN=0 -> 32'h000000EF.
  - Half, SIGN=1 -> 32'hFFFFBEEF.
  - Byte at ADDR 9, SIGN=1 -> 32'hFFFFFFBE.
- Misaligned word (macro off): write 32'hDEADBEEF at ADDR 1 -> word 0 updated; read word at ADDR 1 -> 32'hDEADBEEF. With DMEM_MISALIGN_CHK_EN, the same write pulses MISALIGN and memory is unchanged.
- Read-first collision: word 0 = 32'h11111111; RDEN=WEN=1, ADDR 0, DATA_IN 32'h22222222 -> DATA_OUT=32'h11111111; next read -> 32'h22222222.
- Hold/reset: after a read, RDEN=0 for 3 cycles -> DATA_OUT stable. Assert RST_N=0 mid-cycle -> DATA_OUT=0 immediately, memory word retained on re-read.
